// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : PS/2 keyboard frame receiver with E0/F0 prefix handling and a
//            512-entry pressed-key map.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire          PS2_CLK,
    inout  wire          PS2_DATA,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid,
    output logic         key_break,
    output logic         frame_err
);

    localparam int              CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic               r_parity;
    logic [CNT_W-1:0]   r_to_cnt;
    logic               r_byte_done;
    logic [7:0]         r_byte;
    logic               r_frame_err;
    logic               r_ext;
    logic               r_brk;
    logic [511:0]       r_key_down;
    logic [8:0]         r_last_change;
    logic               r_key_break;

    logic               w_fall;
    logic               w_data;
    logic               w_shift_en;
    logic               w_byte_ok;
    logic               w_err;
    logic               w_timeout;
    logic               w_is_e0;
    logic               w_is_f0;
    logic [8:0]         w_code;
    logic               w_key_valid;

    // Bits [1:0] are the synchronizer; bit 2 holds the previous sample for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], PS2_CLK};
            r_data_sync <= {r_data_sync[0], PS2_DATA};
        end
    end

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data = r_data_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;
        w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (!w_data) w_state_nxt = S_DATA;
                    else         w_err       = 1'b1;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fall) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    if (w_data && (^{r_shift, r_parity})) w_byte_ok = 1'b1;
                    else                                  w_err     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_done <= 1'b0;
            r_byte      <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_bit_cnt <= 3'd0;
            if (w_shift_en) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if ((r_state == S_PARITY) && w_fall) r_parity <= w_data;
            if ((w_state_nxt == S_IDLE) || w_fall) r_to_cnt <= '0;
            else                                   r_to_cnt <= r_to_cnt + CNT_W'(1);
            r_byte_done <= w_byte_ok;
            if (w_byte_ok) r_byte <= r_shift;
            r_frame_err <= w_err;
        end
    end

    // Byte handling happens the cycle after the stop-bit fall.
    assign w_is_e0     = (r_byte == 8'hE0);
    assign w_is_f0     = (r_byte == 8'hF0);
    assign w_code      = {r_ext, r_byte};
    assign w_key_valid = r_byte_done && !w_is_e0 && !w_is_f0 && (r_key_down[w_code] == r_brk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_key_down    <= '0;
            r_last_change <= 9'h000;
            r_key_break   <= 1'b0;
        end else if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_done) begin
            if (w_is_e0) begin
                r_ext <= 1'b1;
            end else if (w_is_f0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (w_key_valid) begin
                    r_key_down[w_code] <= ~r_brk;
                    r_last_change      <= w_code;
                    r_key_break        <= r_brk;
                end
            end
        end
    end

    assign key_down    = r_key_down;
    assign last_change = r_last_change;
    assign key_break   = r_key_break;
    assign key_valid   = w_key_valid;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire
